// File: rtl/rf_dump_reader_pkg.sv
// Shared definitions for register-file debug clients: index/data widths and
// the dump reader state encoding.
package rf_dump_reader_pkg;

  localparam int IDX_W  = 5;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEL  = 2'd1,
    SEND = 2'd2,
    HOLD = 2'd3
  } state_t;

endpackage

// File: rtl/rf_dump_hold_timer.sv
// Loadable down-counter with a zero flag; times the idle gap between words.
module rf_dump_hold_timer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/rf_dump_reader.sv
// Walks a register index range on the RF debug port and streams each sampled
// value out over a valid/ready interface.
module rf_dump_reader
  import rf_dump_reader_pkg::*;
#(
  parameter int HOLD_CYCLES = 0,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [IDX_W-1:0]  first_idx,
  input  logic [IDX_W-1:0]  last_idx,
  output logic [IDX_W-1:0]  reg_sel,
  input  logic [DATA_W-1:0] reg_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam logic [CNT_W-1:0] HOLD_LOAD =
    (HOLD_CYCLES == 0) ? '0 : CNT_W'(HOLD_CYCLES - 1);

  state_t           state, state_nx;
  logic [IDX_W-1:0] idx, end_idx;
  logic             hold_load, hold_zero;
  logic             handshake;

  assign handshake = out_valid && out_ready;
  assign busy      = (state != IDLE);

  // abort takes priority over every other transition, including a start in IDLE
  always_comb begin
    state_nx  = state;
    hold_load = 1'b0;
    case (state)
      IDLE: if (start && !abort) state_nx = SEL;
      SEL:  state_nx = abort ? IDLE : SEND;
      SEND: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (handshake) begin
          if (out_last) begin
            state_nx = IDLE;
          end else if (HOLD_CYCLES == 0) begin
            state_nx = SEL;
          end else begin
            state_nx  = HOLD;
            hold_load = 1'b1;
          end
        end
      end
      HOLD: begin
        if (abort)          state_nx = IDLE;
        else if (hold_zero) state_nx = SEL;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= '0;
      end_idx   <= '0;
      reg_sel   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            idx     <= first_idx;
            end_idx <= last_idx;
            reg_sel <= first_idx;
          end
        end
        SEL: begin
          if (!abort) begin
            out_data  <= reg_data;
            out_idx   <= idx;
            out_last  <= (idx == end_idx);
            out_valid <= 1'b1;
          end
        end
        SEND: begin
          if (abort) begin
            out_valid <= 1'b0;
          end else if (handshake) begin
            out_valid <= 1'b0;
            if (out_last) begin
              done <= 1'b1;
            end else begin
              // index wraps 31 -> 0 naturally in IDX_W bits
              idx     <= idx + IDX_W'(1);
              reg_sel <= idx + IDX_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  rf_dump_hold_timer #(
    .CNT_W (CNT_W)
  ) u_hold_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (hold_load),
    .load_val (HOLD_LOAD),
    .dec      (state == HOLD),
    .zero     (hold_zero)
  );

endmodule

// File: tb/tb_rf_dump_reader.sv
// Bench for rf_dump_reader: two instances (no gap and a 3-cycle gap) share the
// stimulus and are checked every cycle against a word-queue reference model.
`timescale 1ns/1ps
module tb_rf_dump_reader;
  import rf_dump_reader_pkg::*;

  localparam int H0 = 0;
  localparam int H1 = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        out_ready = 1'b1;
  logic [4:0]  first_idx = '0;
  logic [4:0]  last_idx = '0;

  logic [4:0]  sel_a   [2];
  logic [31:0] rdata_a [2];
  logic        valid_a [2];
  logic [31:0] data_a  [2];
  logic [4:0]  oidx_a  [2];
  logic        last_a  [2];
  logic        busy_a  [2];
  logic        done_a  [2];

  logic [31:0] rf [32];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rdata_a[0] = rf[sel_a[0]];
  assign rdata_a[1] = rf[sel_a[1]];

  rf_dump_reader #(.HOLD_CYCLES(H0), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .first_idx(first_idx), .last_idx(last_idx),
    .reg_sel(sel_a[0]), .reg_data(rdata_a[0]),
    .out_valid(valid_a[0]), .out_ready(out_ready),
    .out_data(data_a[0]), .out_idx(oidx_a[0]), .out_last(last_a[0]),
    .busy(busy_a[0]), .done(done_a[0])
  );

  rf_dump_reader #(.HOLD_CYCLES(H1), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .first_idx(first_idx), .last_idx(last_idx),
    .reg_sel(sel_a[1]), .reg_data(rdata_a[1]),
    .out_valid(valid_a[1]), .out_ready(out_ready),
    .out_data(data_a[1]), .out_idx(oidx_a[1]), .out_last(last_a[1]),
    .busy(busy_a[1]), .done(done_a[1])
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: a dump is a count of words starting at an index; a word
  // appears 2 cycles after start, and 2+HOLD cycles after each accepted word.
  logic       m_busy [2];
  logic       m_done [2];
  logic [4:0] m_idx  [2];
  int         m_rem  [2];
  int         m_gap  [2];
  int         last_hs[2];
  int         spacing[2];
  int         cyc_cnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        m_busy[d] = 1'b0; m_done[d] = 1'b0; m_idx[d] = '0;
        m_rem[d] = 0; m_gap[d] = 0; last_hs[d] = 0; spacing[d] = 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        logic exp_valid;
        exp_valid = m_busy[d] && (m_gap[d] == 0);
        chk($sformatf("busy%0d", d), 64'(busy_a[d]), 64'(m_busy[d]));
        chk($sformatf("done%0d", d), 64'(done_a[d]), 64'(m_done[d]));
        chk($sformatf("valid%0d", d), 64'(valid_a[d]), 64'(exp_valid));
        if (exp_valid) begin
          chk($sformatf("idx%0d", d),  64'(oidx_a[d]), 64'(m_idx[d]));
          chk($sformatf("data%0d", d), 64'(data_a[d]), 64'(rf[m_idx[d]]));
          chk($sformatf("last%0d", d), 64'(last_a[d]), 64'(m_rem[d] == 1));
        end
        m_done[d] = 1'b0;
        if (m_busy[d]) begin
          if (abort) begin
            m_busy[d] = 1'b0;
          end else if (m_gap[d] != 0) begin
            m_gap[d]--;
          end else if (out_ready) begin
            spacing[d] = cyc_cnt - last_hs[d];
            last_hs[d] = cyc_cnt;
            if (m_rem[d] == 1) begin
              m_busy[d] = 1'b0;
              m_done[d] = 1'b1;
            end else begin
              m_idx[d] = m_idx[d] + 5'd1;
              m_rem[d]--;
              m_gap[d] = 1 + ((d == 0) ? H0 : H1);
            end
          end
        end else if (start && !abort) begin
          m_busy[d] = 1'b1;
          m_idx[d]  = first_idx;
          m_rem[d]  = ((int'(last_idx) - int'(first_idx) + 32) % 32) + 1;
          m_gap[d]  = 1;
        end
      end
    end
    cyc_cnt++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_valid%0d", tag, d), 64'(valid_a[d]), 64'(0));
      chk($sformatf("%s_busy%0d", tag, d),  64'(busy_a[d]),  64'(0));
      chk($sformatf("%s_done%0d", tag, d),  64'(done_a[d]),  64'(0));
      chk($sformatf("%s_data%0d", tag, d),  64'(data_a[d]),  64'(0));
      chk($sformatf("%s_idx%0d", tag, d),   64'(oidx_a[d]),  64'(0));
      chk($sformatf("%s_last%0d", tag, d),  64'(last_a[d]),  64'(0));
      chk($sformatf("%s_sel%0d", tag, d),   64'(sel_a[d]),   64'(0));
    end
  endtask

  task automatic do_start(input logic [4:0] f, input logic [4:0] l);
    first_idx = f;
    last_idx  = l;
    start     = 1'b1;
    cyc();
    start     = 1'b0;
    first_idx = 5'($urandom);
    last_idx  = 5'($urandom);
  endtask

  task automatic wait_idle(input int budget, input bit rnd_ready, input bit rnd_abort);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!busy_a[0] && !busy_a[1]) begin
        ok = 1'b1;
        break;
      end
      out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      abort     = rnd_abort && ($urandom_range(0, 199) == 0);
      cyc();
    end
    abort     = 1'b0;
    out_ready = 1'b1;
    if (!ok) chk("idle_timeout", 64'({busy_a[0], busy_a[1]}), 64'(0));
    cyc();
  endtask

  task automatic wait_valid(input int d, input logic [4:0] want, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      cyc();
      if (valid_a[d] && (oidx_a[d] == want)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("valid_timeout", 64'(valid_a[d]), 64'(1));
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + 32'(i);
    rf[0] = '0;

    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    rst = 1'b0;
    cyc();

    // Basic range, then wrapping range through x0
    do_start(5'd1, 5'd4);
    wait_idle(200, 1'b0, 1'b0);
    do_start(5'd30, 5'd1);
    wait_idle(200, 1'b0, 1'b0);

    // Backpressure on the second word for 5 cycles
    do_start(5'd0, 5'd3);
    wait_valid(0, 5'd1, 20);
    out_ready = 1'b0;
    repeat (5) cyc();
    out_ready = 1'b1;
    wait_idle(200, 1'b0, 1'b0);

    // Word spacing with and without a hold gap
    do_start(5'd5, 5'd6);
    wait_idle(200, 1'b0, 1'b0);
    chk("spacing_h0", 64'(spacing[0]), 64'(2 + H0));
    chk("spacing_h3", 64'(spacing[1]), 64'(2 + H1));

    // Abort during SEND of idx 2, then a single-word dump
    do_start(5'd0, 5'd7);
    wait_valid(0, 5'd2, 20);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("abort_busy0", 64'(busy_a[0]), 64'(0));
    chk("abort_valid0", 64'(valid_a[0]), 64'(0));
    wait_idle(50, 1'b0, 1'b0);
    do_start(5'd7, 5'd7);
    wait_idle(200, 1'b0, 1'b0);

    // start while busy is ignored; async reset in the middle of HOLD
    do_start(5'd10, 5'd20);
    repeat (3) cyc();
    do_start(5'd3, 5'd3);
    wait_valid(1, 5'd11, 40);
    cyc();
    chk("pre_rst_busy1", 64'(busy_a[1]), 64'(1));
    #2 rst = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cyc();

    // Randomized dumps with random RF contents, backpressure and aborts
    for (int n = 0; n < 25; n++) begin
      for (int i = 1; i < 32; i++) rf[i] = $urandom;
      do_start(5'($urandom), 5'($urandom));
      wait_idle(1500, 1'b1, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_dump_reader.md
Name: rf_dump_reader

Overview:
- Read-side master for the register file's debug port (reg_sel/reg_data).
- On a start pulse, walks a register index range, samples each register value and emits it as a valid/ready word stream.
- The stream feeds the board display scroller or the debug UART formatter.
- Runs in parallel with the pipeline and never touches the write port.

Parameters:
HOLD_CYCLES, 0, idle gap in cycles inserted after each accepted word; 0 = back-to-back
CNT_W, 32, width of the hold counter; must be able to hold HOLD_CYCLES

Ports:
clk  input  1  clock, rising-edge logic
rst  input  1  reset, asynchronous, active-high
start  input  1  single-cycle request to begin a dump; ignored while busy
abort  input  1  cancels a dump in progress
first_idx  input  5  first register index; sampled on accepted start
last_idx  input  5  last register index; sampled on accepted start
reg_sel  output  5  register index driven to the RF debug port
reg_data  input  32  combinational RF debug read data for reg_sel
out_valid  output  1  stream word valid
out_ready  input  1  downstream accepts the word
out_data  output  32  captured register value
out_idx  output  5  index of out_data
out_last  output  1  word is the final word of the dump
busy  output  1  dump in progress (any state except IDLE)
done  output  1  one-cycle pulse after the last word is accepted

Behaviour:
- Reset values: state=IDLE, reg_sel=0, idx=0, out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0, done=0, hold counter=0.
- Reset asserted mid-dump returns immediately to reset values. No done pulse.
- States: IDLE, SEL, SEND, HOLD.
- IDLE:
  - On start=1, latch first_idx into idx, latch last_idx into end, set reg_sel=first_idx, go to SEL.
  - busy rises the cycle after start.
- SEL (exactly 1 cycle):
  - reg_sel is stable.
  - At the clock edge, capture reg_data into out_data, idx into out_idx, and (idx==end) into out_last.
  - Set out_valid=1 and go to SEND.
  - Start-to-first-valid latency is 2 cycles.
- SEND:
  - out_valid, out_data, out_idx and out_last are held stable until out_valid&&out_ready.
  - On handshake with out_last=1: out_valid=0, done=1 for one cycle, go to IDLE.
  - On handshake with out_last=0: out_valid=0, idx=idx+1 modulo 32, reg_sel=idx+1.
    - If HOLD_CYCLES==0, go to SEL.
    - Otherwise load counter=HOLD_CYCLES-1 and go to HOLD.
- HOLD: decrement the counter each cycle; at 0, go to SEL.
- Steady-state throughput with out_ready tied high and HOLD_CYCLES=0: one word per 2 cycles.
- Range rules:
  - first_idx==last_idx: exactly one word.
  - first_idx>last_idx: the index wraps 31->0, and the word count is 32-first+last+1.
  - A full 32-word dump is first=k, last=k-1 (mod 32).
- Index 0 is emitted normally. reg_data for x0 is 0, supplied by the RF; this block applies no special case.
- A start asserted while busy is ignored. start and abort asserted together in IDLE: abort wins, no dump.
- abort while busy:
  - Next cycle: state=IDLE, out_valid=0, no done pulse, reg_sel holds its last value.
  - This is the only case in which out_valid may drop without a handshake; consumers discard the partial dump.
- The RF may be written during a dump. Each word reflects the RF contents at its own SEL edge; no snapshot consistency across words is required.
- Changes to first_idx or last_idx after an accepted start have no effect on the dump in progress.

Decomposition:
- Shared package: the state encoding (IDLE, SEL, SEND, HOLD as a 2-bit enum), the RF index width constant (5) and the data width constant (32). Other RF clients reuse the widths.
- One natural sub-module: rf_dump_hold_timer, a loadable down-counter with a zero flag that implements HOLD.
- Everything else stays flat.

Test Plan:
1. RF preloaded with r[i]=0x1000_0000+i. Start with first=1, last=4, ready=1 -> four words, idx 1,2,3,4, data 0x10000001..0x10000004; out_last only on idx 4; done pulses once, 1 cycle after the idx-4 handshake; busy falls on the same cycle.
2. Wrap: first=30, last=1 -> idx sequence 30,31,0,1; idx 0 carries data 0.
3. Backpressure: ready held low for 5 cycles on the second word -> out_valid, out_data, out_idx and out_last stay constant for all 5 cycles; no word lost or duplicated.
4. HOLD_CYCLES=3, ready=1, first=5, last=6 -> exactly 3 idle cycles between the idx-5 handshake and the SEL of idx 6; valid-to-valid spacing is 5 cycles.
5. Abort while SEND of idx 2, in a 0..7 dump -> out_valid=0 next cycle, busy=0, no done. A subsequent start with first=last=7 yields a single word, idx 7, with out_last=1.
6. Start while busy ignored, and async rst asserted mid-HOLD -> all outputs return to reset values within the same cycle, without waiting for a clk edge.
